dvi_scanout_engine: RTL

Parametrised successor to the fixed 640x480 timing generator, palette and FIFO-read glue in the DVI display path. Runs entirely in the pixel clock domain. Drains colour codes from the first-word-fall-through side of the cross-clock pixel FIFO, translates them through a run-time-programmable palette, and drives registered RGB, sync and blank to the DVI encoder. Adds configurable timing/polarity, a selectable underflow policy and an underflow counter.

---
 rtl/dvi_scanout_engine.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dvi_scanout_engine.sv
// dvi_scanout_engine
// Pixel-clock-domain scanout for the DVI path. A pair of h/v counters walks
// the raster. Inside the visible region colour codes are popped from a
// first-word-fall-through FIFO and looked up in a programmable palette.
// All visible outputs are registered one cycle behind the counter state.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   en                  scan enable; low parks the raster at (0,0)
//   fifo_dout/empty     head of the colour-code FIFO (FWFT)
//   fifo_rd_en          combinational pop strobe
//   pal_we/addr/data    synchronous palette write port ({R,G,B})
//   pixel_r/g/b         registered pixel colour
//   hsync, vsync, blank registered timing outputs
//   pixel_x, pixel_y    raster coordinate that produced the current output
//   frame_start         one-cycle pulse alongside output pixel (0,0)
//   underflow_cnt       saturating count of cycles that found the FIFO empty
module dvi_scanout_engine #(
  parameter int          H_ACTIVE      = 640,
  parameter int          H_FP          = 16,
  parameter int          H_SYNC        = 96,
  parameter int          H_BP          = 48,
  parameter int          V_ACTIVE      = 480,
  parameter int          V_FP          = 10,
  parameter int          V_SYNC        = 2,
  parameter int          V_BP          = 33,
  parameter bit          HSYNC_POL     = 1'b0,
  parameter bit          VSYNC_POL     = 1'b0,
  parameter int          COLOR_BITS    = 3,
  parameter int          STALL_MODE    = 0,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [COLOR_BITS-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  pal_we,
  input  logic [COLOR_BITS-1:0] pal_addr,
  input  logic [23:0]           pal_data,
  output logic [7:0]            pixel_r,
  output logic [7:0]            pixel_g,
  output logic [7:0]            pixel_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blank,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] pixel_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] pixel_y,
  output logic                  frame_start,
  output logic [15:0]           underflow_cnt
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int HX        = HW + 1;
  localparam int VX        = VW + 1;
  localparam int PAL_DEPTH = 1 << COLOR_BITS;

  // Region bounds are held one bit wider than the counters so that a sync
  // pulse ending exactly at the line/frame total still fits.
  localparam logic [HX-1:0] H_ACT_END  = HX'(H_ACTIVE);
  localparam logic [HX-1:0] H_SYNC_BEG = HX'(H_ACTIVE + H_FP);
  localparam logic [HX-1:0] H_SYNC_END = HX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VX-1:0] V_ACT_END  = VX'(V_ACTIVE);
  localparam logic [VX-1:0] V_SYNC_BEG = VX'(V_ACTIVE + V_FP);
  localparam logic [VX-1:0] V_SYNC_END = VX'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [HX-1:0] h_ext;
  logic [VX-1:0] v_ext;
  logic          active;
  logic          underflow;
  logic          stall;
  logic          h_in_sync;
  logic          v_in_sync;
  logic [23:0]   palette [PAL_DEPTH];

  // Power-on palette: index bit 2 lights red, bit 1 green, bit 0 blue.
  function automatic logic [23:0] pal_default(input int idx);
    logic [23:0] entry;
    entry[23:16] = idx[2] ? 8'hFF : 8'h00;
    entry[15:8]  = idx[1] ? 8'hFF : 8'h00;
    entry[7:0]   = idx[0] ? 8'hFF : 8'h00;
    return entry;
  endfunction

  assign h_ext = {1'b0, h};
  assign v_ext = {1'b0, v};

  always_comb begin
    active     = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    underflow  = active && fifo_empty && en;
    // Only the freeze policy holds the raster on an empty FIFO.
    stall      = underflow && (STALL_MODE == 0);
    fifo_rd_en = active && !fifo_empty && en && !rst;
    h_in_sync  = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    v_in_sync  = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
  end

  // Palette reads are asynchronous and taken before this edge's write lands,
  // so a colliding read sees the previous entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        palette[i] <= pal_default(i);
      end
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      h <= '0;
      v <= '0;
    end else if (!stall) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {pixel_r, pixel_g, pixel_b} <= 24'h0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      blank       <= 1'b1;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      {pixel_r, pixel_g, pixel_b} <= 24'h0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      blank       <= 1'b1;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= h;
      pixel_y     <= v;
      hsync       <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
      // A frozen (0,0) repeats; the pulse waits for the cycle that really
      // emits the first pixel.
      frame_start <= (h == '0) && (v == '0) && !stall;
      if (fifo_rd_en) begin
        {pixel_r, pixel_g, pixel_b} <= palette[fifo_dout];
        blank <= 1'b0;
      end else if (underflow && (STALL_MODE != 0)) begin
        {pixel_r, pixel_g, pixel_b} <= UNDERFLOW_RGB;
        blank <= 1'b0;
      end else begin
        {pixel_r, pixel_g, pixel_b} <= 24'h0;
        blank <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_cnt <= 16'h0;
    end else if (underflow && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'h1;
    end
  end

endmodule
